serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial 4-bit adder for the processor datapath, the additive counterpart to the ripple subtractor. It accepts two 4-bit operands and a carry-in on a start strobe. It computes one sum bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It then presents the registered sum, carry-out and signed overflow with a one-cycle done pulse. This trades three extra cycles of latency for one adder cell in area-constrained configurations of the ALU.

## Interface
Parameters: none; the width is fixed at 4 bits.

- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only when busy=0
- operand_a  input  4  addend A, captured on an accepted start
- operand_b  input  4  addend B, captured on an accepted start
- carry_in  input  1  carry into bit 0, captured on an accepted start
- sum  output  4  registered result; holds until the next completion
- carry  output  1  registered carry-out of bit 3
- overflow  output  1  registered signed overflow: carry into bit 3 XOR carry out of bit 3
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum, carry and overflow are updated

## Operation
- States:
  - IDLE: busy=0.
  - ADD: busy=1, 2-bit bit counter idx runs 0..3.
- Internal registers:
  - a_sh and b_sh: 4-bit shift registers.
  - c: carry flip-flop.
  - s_sh: 4-bit result shift register.
  - c3: carry into bit 3.
- IDLE, start=1:
  - Load a_sh=operand_a, b_sh=operand_b, c=carry_in, idx=0.
  - Go to ADD.
- IDLE, start=0: stay in IDLE. done=0 in every cycle except the completion cycle.
- ADD, each cycle:
  - Compute bit = a_sh[0]^b_sh[0]^c.
  - Compute cout = majority(a_sh[0], b_sh[0], c).
  - Shift s_sh right with bit entering at bit 3.
  - Shift a_sh and b_sh right.
  - Set c=cout.
  - When idx=3, also capture c3 = the c value used in that cycle.
  - Increment idx.
- ADD, idx=3 (last bit):
  - At the clock edge, sum takes the fully shifted result (s_sh shifted once more with the final bit).
  - carry takes the final cout.
  - overflow takes c3 XOR final cout.
  - done=1 for the following cycle.
  - Return to IDLE.
- sum, carry and overflow change only at completion; intermediate shift states are never visible on the outputs.
- start while busy=1: ignored. Operands are not re-captured and the in-flight operation is unaffected. Requests are not queued.
- Start during the done cycle: accepted, because busy=0 in that cycle. done and the new load occur together.
- Arithmetic: {carry, sum} = operand_a + operand_b + carry_in, modulo 32. Unsigned and two's-complement results are both exact in sum; overflow flags the signed case.
- Operand inputs are don't-care except in the cycle where start is accepted.

## Timing
- Reset values: sum=0, carry=0, overflow=0, busy=0, done=0. State is IDLE, idx=0, and all internal registers are 0.
- rst has priority over start and over any in-flight operation. On a mid-operation reset, state returns to IDLE, no done is produced, and outputs are zeroed at that edge.
- Latency, with start sampled high at edge E0:
  - busy=1 after E0.
  - Bits 0..3 are processed at edges E1..E4.
  - After E4: busy=0, done=1, and results are valid.
  - done deasserts after E5 unless a new operation completes at that edge, which is impossible because the minimum spacing is 5 cycles.
- Throughput: one addition per 5 cycles with back-to-back starts.
- done is never high while busy=1.

## Test plan
- Reset, then start with a=3, b=5, cin=0.
  - Expect busy high for 4 cycles.
  - done at the 5th cycle after start with sum=8, carry=0, overflow=1.
- a=15, b=1, cin=0: expect sum=0, carry=1, overflow=0.
- a=7, b=7, cin=1: expect sum=15, carry=0, overflow=1.
- a=8, b=8, cin=0: expect sum=0, carry=1, overflow=1.
- Start a=2, b=2; re-pulse start with a=9, b=9 two cycles later.
  - Expect a single done with sum=4, carry=0.
  - Second request dropped.
- Start a=6, b=5. Assert rst at the 2nd ADD cycle.
  - Expect no done and all outputs 0.
  - Then start a=1, b=1 in the done cycle of a prior op (a=4, b=4 → 8). Expect both completions, 5 cycles apart: sum=8 then sum=2.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial 4-bit adder: one full-adder slice plus a carry flop, LSB first.
// The result, carry-out and signed overflow are registered at completion with a one-cycle done pulse.
module serial_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] operand_a,
  input  logic [3:0] operand_b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry,
  output logic       overflow,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {StIdle, StAdd} state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] a_sh_q, a_sh_d;
  logic [3:0] b_sh_q, b_sh_d;
  logic [3:0] s_sh_q, s_sh_d;
  logic       c_q, c_d;
  logic       c3_q, c3_d;
  logic [3:0] sum_q, sum_d;
  logic       carry_q, carry_d;
  logic       overflow_q, overflow_d;
  logic       done_q, done_d;

  logic       sum_bit;
  logic       cout;

  // Single full-adder slice working on the current LSBs and the carry flop.
  always_comb begin
    sum_bit = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    cout    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  end

  // Next-state logic: operand load in idle, one bit per cycle while adding.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    s_sh_d     = s_sh_q;
    c_d        = c_q;
    c3_d       = c3_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = operand_a;
          b_sh_d  = operand_b;
          c_d     = carry_in;
          s_sh_d  = 4'd0;
          idx_d   = 2'd0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        s_sh_d = {sum_bit, s_sh_q[3:1]};
        a_sh_d = {1'b0, a_sh_q[3:1]};
        b_sh_d = {1'b0, b_sh_q[3:1]};
        c_d    = cout;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // c_q here is the carry into bit 3, needed for signed overflow.
          c3_d       = c_q;
          sum_d      = {sum_bit, s_sh_q[3:1]};
          carry_d    = cout;
          overflow_d = c_q ^ cout;
          done_d     = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      a_sh_q     <= 4'd0;
      b_sh_q     <= 4'd0;
      s_sh_q     <= 4'd0;
      c_q        <= 1'b0;
      c3_q       <= 1'b0;
      sum_q      <= 4'd0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      s_sh_q     <= s_sh_d;
      c_q        <= c_d;
      c3_q       <= c3_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    sum      = sum_q;
    carry    = carry_q;
    overflow = overflow_q;
    done     = done_q;
    busy     = (state_q == StAdd);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic       carry_in;
  logic [3:0] sum;
  logic       carry;
  logic       overflow;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  serial_adder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .carry_in (carry_in),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge (E0); returns 1 ns after E0.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    carry_in  = cin;
    step();
    start     = 1'b0;
    operand_a = 4'hx;
    operand_b = 4'hx;
    carry_in  = 1'bx;
  endtask

  // Wait (bounded) for done; n = edges after call until done seen, 10 on timeout.
  task automatic wait_done(output int n);
    n = 10;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input int exp_sum, input int exp_c,
                        input int exp_ovf);
    int n;
    start_op(a, b, cin);
    check_eq({tag, " busy_after_start"}, int'(busy), 1);
    wait_done(n);
    check_eq({tag, " latency"}, n, 3);
    check_eq({tag, " sum"}, int'(sum), exp_sum);
    check_eq({tag, " carry"}, int'(carry), exp_c);
    check_eq({tag, " overflow"}, int'(overflow), exp_ovf);
    check_eq({tag, " busy_at_done"}, int'(busy), 0);
    step();
    check_eq({tag, " done_pulse_width"}, int'(done), 0);
  endtask

  initial begin
    int n;
    int busy_cycles;
    int extra_dones;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    operand_a = 4'd0;
    operand_b = 4'd0;
    carry_in  = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset sum", int'(sum), 0);
    check_eq("reset carry", int'(carry), 0);
    check_eq("reset overflow", int'(overflow), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    step();

    // 3+5: busy for exactly four sampled cycles, then done.
    start_op(4'd3, 4'd5, 1'b0);
    busy_cycles = 0;
    n = 10;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        n = i;
        break;
      end
      step();
    end
    check_eq("3+5 busy_cycles", busy_cycles, 4);
    check_eq("3+5 done_cycle", n, 4);
    check_eq("3+5 sum", int'(sum), 8);
    check_eq("3+5 carry", int'(carry), 0);
    check_eq("3+5 overflow", int'(overflow), 1);
    step();
    check_eq("3+5 done_pulse_width", int'(done), 0);

    run_op("15+1", 4'd15, 4'd1, 1'b0, 0, 1, 0);
    run_op("7+7+1", 4'd7, 4'd7, 1'b1, 15, 0, 1);
    run_op("8+8", 4'd8, 4'd8, 1'b0, 0, 1, 1);
    run_op("5+9+1", 4'd5, 4'd9, 1'b1, 15, 0, 0);

    // Start while busy is dropped.
    start_op(4'd2, 4'd2, 1'b0);
    step();
    start     = 1'b1;
    operand_a = 4'd9;
    operand_b = 4'd9;
    carry_in  = 1'b0;
    step();
    start = 1'b0;
    wait_done(n);
    check_eq("drop latency", n, 1);
    check_eq("drop sum", int'(sum), 4);
    check_eq("drop carry", int'(carry), 0);
    extra_dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) extra_dones++;
      if (busy) extra_dones++;
    end
    check_eq("drop no_second_op", extra_dones, 0);

    // Reset during the second ADD cycle.
    start_op(4'd6, 4'd5, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst sum", int'(sum), 0);
    check_eq("midrst carry", int'(carry), 0);
    check_eq("midrst overflow", int'(overflow), 0);
    check_eq("midrst busy", int'(busy), 0);
    check_eq("midrst done", int'(done), 0);
    extra_dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) extra_dones++;
    end
    check_eq("midrst no_done", extra_dones, 0);

    // Back-to-back: new start accepted in the done cycle.
    start_op(4'd4, 4'd4, 1'b0);
    wait_done(n);
    check_eq("b2b first latency", n, 3);
    check_eq("b2b first sum", int'(sum), 8);
    check_eq("b2b first overflow", int'(overflow), 1);
    start_op(4'd1, 4'd1, 1'b0);
    check_eq("b2b busy_after_done", int'(busy), 1);
    check_eq("b2b done_cleared", int'(done), 0);
    wait_done(n);
    check_eq("b2b second spacing", n, 3);
    check_eq("b2b second sum", int'(sum), 2);
    check_eq("b2b second carry", int'(carry), 0);
    check_eq("b2b second overflow", int'(overflow), 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
